// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite programming scheduler.
package sprite_pkg;

    localparam int ID_W    = 6;
    localparam int ADDR_W  = 16;
    localparam int COORD_W = 8;
    localparam int CMD_W   = 39;

    localparam logic OP_SET   = 1'b0;
    localparam logic OP_CLEAR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_HOLD   = 2'd3
    } state_e;

    typedef struct packed {
        logic               op;
        logic [ID_W-1:0]    id;
        logic [ADDR_W-1:0]  addr;
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } cmd_t;

endpackage

// File: rtl/sprite_cmd_fifo.sv
// Synchronous FIFO holding queued sprite commands; head entry is visible on rdata_o.
module sprite_cmd_fifo #(
    parameter int WIDTH = 39,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     clear,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_q;
    logic [PW-1:0]    rd_q;
    logic [PW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == (PW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk) begin
        if (clear) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + PW'(1);
            if (do_pop)  rd_q <= rd_q + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (PW+1)'(1);
                2'b01:   count_q <= count_q - (PW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= wdata_i;
    end

endmodule

// File: rtl/sprite_program_scheduler.sv
// Drains queued sprite commands onto the daisy-chain programming bus,
// one SETUP / STROBE / HOLD sequence per command, optionally gated on vblank.
module sprite_program_scheduler
    import sprite_pkg::*;
#(
    parameter int NUM_SPRITES   = 8,
    parameter int FIFO_DEPTH    = 4,
    parameter int STROBE_CYCLES = 2,
    parameter int VBLANK_ONLY   = 1
) (
    input  logic                          clk,
    input  logic                          clear,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic                          req_op,
    input  logic [ID_W-1:0]               req_sprite_id,
    input  logic [ADDR_W-1:0]             req_address,
    input  logic [COORD_W-1:0]            req_x,
    input  logic [COORD_W-1:0]            req_y,
    input  logic                          vblank,
    output logic [ID_W-1:0]               requested_sprite_id,
    output logic [ADDR_W-1:0]             set_address,
    output logic [COORD_W-1:0]            setx,
    output logic [COORD_W-1:0]            sety,
    output logic                          program_active,
    output logic                          clear_out,
    output logic                          busy,
    output logic                          err_bad_id,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int CNT_W = $clog2(STROBE_CYCLES + 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               clr_q, clr_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [COORD_W-1:0] x_q, x_d;
    logic [COORD_W-1:0] y_q, y_d;
    logic               pa_q, pa_d;
    logic               co_q, co_d;
    logic               err_q, err_d;

    logic [CMD_W-1:0]   push_data;
    logic [CMD_W-1:0]   head_raw;
    cmd_t               head;
    logic               fifo_full;
    logic               fifo_empty;
    logic               pop;

    assign push_data = {req_op, req_sprite_id, req_address, req_x, req_y};
    assign head      = head_raw;

    sprite_cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .clear   (clear),
        .push_i  (req_valid),
        .wdata_i (push_data),
        .pop_i   (pop),
        .rdata_o (head_raw),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clr_d   = clr_q;
        id_d    = id_q;
        addr_d  = addr_q;
        x_d     = x_q;
        y_d     = y_q;
        err_d   = err_q;
        pop     = 1'b0;
        pa_d    = 1'b0;
        co_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty && (VBLANK_ONLY == 0 || vblank)) begin
                    pop = 1'b1;
                    if (head.op == OP_CLEAR) begin
                        clr_d   = 1'b1;
                        state_d = ST_SETUP;
                    end else if (int'(head.id) < NUM_SPRITES) begin
                        clr_d   = 1'b0;
                        id_d    = head.id;
                        addr_d  = head.addr;
                        x_d     = head.x;
                        y_d     = head.y;
                        state_d = ST_SETUP;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_SETUP: begin
                state_d = ST_STROBE;
                cnt_d   = CNT_W'(STROBE_CYCLES);
                pa_d    = !clr_q;
                co_d    = clr_q;
            end
            // Strobe flops are computed one cycle ahead so they drop on the edge leaving STROBE.
            ST_STROBE: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_HOLD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                    pa_d  = !clr_q;
                    co_d  = clr_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            clr_q   <= 1'b0;
            id_q    <= '0;
            addr_q  <= '0;
            x_q     <= '0;
            y_q     <= '0;
            pa_q    <= 1'b0;
            co_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            clr_q   <= clr_d;
            id_q    <= id_d;
            addr_q  <= addr_d;
            x_q     <= x_d;
            y_q     <= y_d;
            pa_q    <= pa_d;
            co_q    <= co_d;
            err_q   <= err_d;
        end
    end

    assign req_ready           = !fifo_full;
    assign requested_sprite_id = id_q;
    assign set_address         = addr_q;
    assign setx                = x_q;
    assign sety                = y_q;
    assign program_active      = pa_q;
    assign clear_out           = co_q;
    assign err_bad_id          = err_q;
    assign busy                = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_sprite_program_scheduler.sv
// Self-checking bench: strobe events are captured by a monitor and scored
// against an in-order queue of expected bus contents built at push time.
module tb_sprite_program_scheduler;

    localparam int NS  = 8;
    localparam int STB = 2;

    logic        clk = 1'b0;
    logic        clear = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_op = 1'b0;
    logic [5:0]  req_sprite_id = '0;
    logic [15:0] req_address = '0;
    logic [7:0]  req_x = '0;
    logic [7:0]  req_y = '0;
    logic        vblank = 1'b0;
    logic [5:0]  requested_sprite_id;
    logic [15:0] set_address;
    logic [7:0]  setx;
    logic [7:0]  sety;
    logic        program_active;
    logic        clear_out;
    logic        busy;
    logic        err_bad_id;
    logic [2:0]  fifo_count;

    always #5 clk = ~clk;

    sprite_program_scheduler #(
        .NUM_SPRITES   (NS),
        .FIFO_DEPTH    (4),
        .STROBE_CYCLES (STB),
        .VBLANK_ONLY   (1)
    ) dut (
        .clk                 (clk),
        .clear               (clear),
        .req_valid           (req_valid),
        .req_ready           (req_ready),
        .req_op              (req_op),
        .req_sprite_id       (req_sprite_id),
        .req_address         (req_address),
        .req_x               (req_x),
        .req_y               (req_y),
        .vblank              (vblank),
        .requested_sprite_id (requested_sprite_id),
        .set_address         (set_address),
        .setx                (setx),
        .sety                (sety),
        .program_active      (program_active),
        .clear_out           (clear_out),
        .busy                (busy),
        .err_bad_id          (err_bad_id),
        .fifo_count          (fifo_count)
    );

    typedef struct {
        logic [38:0] val;
        int          len;
        int          start;
        bit          ok;
    } ev_t;

    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    ev_t         evq[$];
    logic [38:0] exp_q[$];
    logic [37:0] last_bus = '0;
    bit          exp_err = 0;
    bit          in_ev = 0;
    ev_t         cur;

    // Monitor: one record per strobe pulse; a pulse cut short by reset is dropped.
    always @(posedge clk or negedge clk) begin
        if (clk) begin
            if (clear) in_ev = 0;
        end else begin
            cyc++;
            if (clear) begin
                in_ev = 0;
            end else if (program_active || clear_out) begin
                if (!in_ev) begin
                    in_ev     = 1;
                    cur.val   = {clear_out, requested_sprite_id, set_address, setx, sety};
                    cur.len   = 1;
                    cur.start = cyc;
                    cur.ok    = !(program_active && clear_out);
                end else begin
                    cur.len++;
                    if ({clear_out, requested_sprite_id, set_address, setx, sety} !== cur.val ||
                        (program_active && clear_out))
                        cur.ok = 0;
                end
            end else if (in_ev) begin
                in_ev = 0;
                evq.push_back(cur);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clear = 1'b1;
        req_valid = 1'b0;
        tick();
        tick();
        clear = 1'b0;
        evq.delete();
        exp_q.delete();
        exp_err = 0;
        last_bus = '0;
    endtask

    task automatic push_cmd(input bit op, input logic [5:0] id, input logic [15:0] a,
                            input logic [7:0] x, input logic [7:0] y, input bit rand_vb);
        bit accepted = 0;
        bit rdy;
        req_valid = 1'b1;
        req_op = op;
        req_sprite_id = id;
        req_address = a;
        req_x = x;
        req_y = y;
        for (int i = 0; i < 300 && !accepted; i++) begin
            if (rand_vb) vblank = 1'($urandom_range(0, 1));
            @(negedge clk);
            rdy = req_ready;
            tick();
            if (rdy) accepted = 1;
        end
        req_valid = 1'b0;
        n_checks++;
        if (!accepted) begin
            n_fail++;
            $display("FAIL push_accept: got not accepted, want accepted within 300 cycles");
        end else if (op) begin
            exp_q.push_back({1'b1, last_bus});
        end else if (int'(id) < NS) begin
            last_bus = {id, a, x, y};
            exp_q.push_back({1'b0, last_bus});
        end else begin
            exp_err = 1;
        end
    endtask

    task automatic push_rand_set(input bit rand_vb);
        push_cmd(1'b0, 6'($urandom_range(0, NS-1)), 16'($urandom), 8'($urandom), 8'($urandom), rand_vb);
    endtask

    task automatic wait_idle(input string name, input int budget);
        bit done = 0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk);
            if (!busy) done = 1;
        end
        tick();
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL %s idle: got busy after %0d cycles, want idle", name, budget);
        end
    endtask

    task automatic test_reset();
        clear = 1'b1;
        req_valid = 1'b1;
        vblank = 1'b1;
        tick();
        tick();
        @(negedge clk);
        n_checks++;
        if ({requested_sprite_id, set_address, setx, sety} !== 38'd0) begin
            n_fail++;
            $display("FAIL reset_bus: got %h, want 0", {requested_sprite_id, set_address, setx, sety});
        end
        n_checks++;
        if ({program_active, clear_out, busy, err_bad_id} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b, want 0000", {program_active, clear_out, busy, err_bad_id});
        end
        n_checks++;
        if (fifo_count !== 3'd0 || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_fifo: got count %0d ready %b, want 0 1", fifo_count, req_ready);
        end
        req_valid = 1'b0;
        tick();
        do_reset();
    endtask

    task automatic test_single_set();
        logic [43:0] got, want;
        logic [37:0] bus;
        do_reset();
        vblank = 1'b1;
        push_cmd(1'b0, 6'd3, 16'h0040, 8'd20, 8'd30, 0);
        // c=0 queued, 1 SETUP, 2-3 STROBE, 4 HOLD, 5 IDLE
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            bus  = (c >= 1) ? {6'd3, 16'h0040, 8'd20, 8'd30} : 38'd0;
            want = {bus, 1'(c == 2 || c == 3), 1'b0, 1'(c < 5), 3'(c == 0)};
            got  = {requested_sprite_id, set_address, setx, sety, program_active, clear_out, busy, fifo_count};
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL single_set c%0d: got %h, want %h", c, got, want);
            end
            tick();
        end
        n_checks++;
        if (evq.size() != 1 || evq[0].len != STB) begin
            n_fail++;
            $display("FAIL single_set events: got %0d events, want 1 of length %0d", evq.size(), STB);
        end
        evq.delete();
        exp_q.delete();
    endtask

    task automatic test_vblank_gating();
        ev_t e;
        logic [38:0] x;
        do_reset();
        vblank = 1'b0;
        push_rand_set(0);
        push_rand_set(0);
        repeat (10) tick();
        n_checks++;
        if (evq.size() != 0 || fifo_count !== 3'd2) begin
            n_fail++;
            $display("FAIL gating_hold: got %0d strobes count %0d, want 0 strobes count 2", evq.size(), fifo_count);
        end
        vblank = 1'b1;
        wait_idle("gating", 100);
        n_checks++;
        if (evq.size() != 2 || evq[1].start - evq[0].start != STB + 3) begin
            n_fail++;
            $display("FAIL gating_spacing: got %0d events, want 2 events %0d cycles apart", evq.size(), STB + 3);
        end
        while (evq.size() != 0 && exp_q.size() != 0) begin
            e = evq.pop_front();
            x = exp_q.pop_front();
            n_checks++;
            if (e.val !== x || e.len != STB || !e.ok) begin
                n_fail++;
                $display("FAIL gating_ev: got %h len %0d ok %0d, want %h len %0d ok 1", e.val, e.len, e.ok, x, STB);
            end
        end
    endtask

    task automatic test_full();
        ev_t e;
        logic [38:0] x;
        int n = 0;
        do_reset();
        vblank = 1'b0;
        repeat (4) push_rand_set(0);
        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b0 || fifo_count !== 3'd4) begin
            n_fail++;
            $display("FAIL full_flag: got ready %b count %0d, want 0 4", req_ready, fifo_count);
        end
        tick();
        req_valid = 1'b1;
        repeat (3) tick();
        n_checks++;
        if (fifo_count !== 3'd4) begin
            n_fail++;
            $display("FAIL full_hold: got count %0d, want 4", fifo_count);
        end
        vblank = 1'b1;
        push_rand_set(0);
        wait_idle("full", 200);
        while (evq.size() != 0 && exp_q.size() != 0) begin
            e = evq.pop_front();
            x = exp_q.pop_front();
            n++;
            n_checks++;
            if (e.val !== x || e.len != STB || !e.ok) begin
                n_fail++;
                $display("FAIL full_ev%0d: got %h len %0d ok %0d, want %h len %0d ok 1", n, e.val, e.len, e.ok, x, STB);
            end
        end
        n_checks++;
        if (n != 5 || evq.size() != 0) begin
            n_fail++;
            $display("FAIL full_total: got %0d matched + %0d extra, want 5 + 0", n, evq.size());
        end
    endtask

    task automatic test_bad_id();
        ev_t e;
        logic [38:0] x;
        do_reset();
        vblank = 1'b1;
        push_cmd(1'b0, 6'd9, 16'h1234, 8'd1, 8'd2, 0);
        push_cmd(1'b0, 6'd2, 16'hBEEF, 8'd7, 8'd9, 0);
        wait_idle("bad_id", 50);
        n_checks++;
        if (evq.size() != 1 || exp_q.size() != 1) begin
            n_fail++;
            $display("FAIL bad_id_count: got %0d strobes, want 1", evq.size());
        end
        while (evq.size() != 0 && exp_q.size() != 0) begin
            e = evq.pop_front();
            x = exp_q.pop_front();
            n_checks++;
            if (e.val !== x || e.len != STB || !e.ok) begin
                n_fail++;
                $display("FAIL bad_id_ev: got %h len %0d, want %h len %0d", e.val, e.len, x, STB);
            end
        end
        repeat (5) tick();
        n_checks++;
        if (err_bad_id !== exp_err || exp_err != 1) begin
            n_fail++;
            $display("FAIL bad_id_sticky: got %b, want 1", err_bad_id);
        end
        evq.delete();
        exp_q.delete();
    endtask

    task automatic test_clear_cmd();
        ev_t e;
        logic [38:0] x;
        push_cmd(1'b1, 6'($urandom), 16'($urandom), 8'($urandom), 8'($urandom), 0);
        wait_idle("clear_cmd", 50);
        n_checks++;
        if (evq.size() != 1 || exp_q.size() != 1) begin
            n_fail++;
            $display("FAIL clear_cmd_count: got %0d strobes, want 1", evq.size());
        end
        while (evq.size() != 0 && exp_q.size() != 0) begin
            e = evq.pop_front();
            x = exp_q.pop_front();
            n_checks++;
            if (e.val !== x || e.len != STB || !e.ok) begin
                n_fail++;
                $display("FAIL clear_cmd_ev: got %h len %0d ok %0d, want %h len %0d ok 1", e.val, e.len, e.ok, x, STB);
            end
        end
        n_checks++;
        if ({requested_sprite_id, set_address, setx, sety} !== last_bus) begin
            n_fail++;
            $display("FAIL clear_cmd_bus: got %h, want %h", {requested_sprite_id, set_address, setx, sety}, last_bus);
        end
    endtask

    task automatic test_reset_mid_strobe();
        bit seen = 0;
        do_reset();
        vblank = 1'b0;
        repeat (3) push_rand_set(0);
        vblank = 1'b1;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (program_active) seen = 1;
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL midstrobe_start: got no strobe in 20 cycles, want strobe");
        end
        #1 clear = 1'b1;
        tick();
        clear = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({program_active, clear_out, busy, fifo_count} !== 6'd0) begin
            n_fail++;
            $display("FAIL midstrobe_reset: got pa %b co %b busy %b count %0d, want all 0",
                     program_active, clear_out, busy, fifo_count);
        end
        exp_q.delete();
        last_bus = '0;
        repeat (20) tick();
        n_checks++;
        if (evq.size() != 0) begin
            n_fail++;
            $display("FAIL midstrobe_after: got %0d strobes, want 0", evq.size());
        end
        evq.delete();
    endtask

    task automatic test_random();
        ev_t e;
        logic [38:0] x;
        int n = 0;
        do_reset();
        for (int i = 0; i < 40; i++)
            push_cmd(1'($urandom_range(0, 4) == 0), 6'($urandom_range(0, 11)),
                     16'($urandom), 8'($urandom), 8'($urandom), 1);
        vblank = 1'b1;
        n = exp_q.size();
        wait_idle("random", 1000);
        n_checks++;
        if (evq.size() != n) begin
            n_fail++;
            $display("FAIL random_count: got %0d strobes, want %0d", evq.size(), n);
        end
        while (evq.size() != 0 && exp_q.size() != 0) begin
            e = evq.pop_front();
            x = exp_q.pop_front();
            n_checks++;
            if (e.val !== x || e.len != STB || !e.ok) begin
                n_fail++;
                $display("FAIL random_ev: got %h len %0d ok %0d, want %h len %0d ok 1", e.val, e.len, e.ok, x, STB);
            end
        end
        n_checks++;
        if (err_bad_id !== exp_err) begin
            n_fail++;
            $display("FAIL random_err: got %b, want %b", err_bad_id, exp_err);
        end
    endtask

    initial begin
        test_reset();
        test_single_set();
        test_vblank_gating();
        test_full();
        test_bad_id();
        test_clear_cmd();
        test_reset_mid_strobe();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
